// File: rtl/keypad_scanner_pkg.sv
// Shared encodings and helpers for the 4x4 keypad scanner.
// Row drive and column sense are both active-low.
package keypad_scanner_pkg;

    typedef enum logic [1:0] {
        SCAN        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } state_e;

    localparam logic [3:0] ROWS_IDLE = 4'b1110;
    localparam logic [3:0] COLS_NONE = 4'b1111;

    typedef struct packed {
        logic       found;
        logic [1:0] col;
    } col_hit_t;

    // Lowest-index low column wins, so scan from col 3 down and let col 0 overwrite.
    function automatic col_hit_t find_col(input logic [3:0] cs);
        col_hit_t hit;
        hit.found = 1'b0;
        hit.col   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!cs[i]) begin
                hit.found = 1'b1;
                hit.col   = 2'(i);
            end
        end
        return hit;
    endfunction

    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_scanner_key_sync.sv
// Two-flop synchronizer for the asynchronous column inputs.
// Resets to "no column low" so reset never looks like a key press.
module key_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);
    import keypad_scanner_pkg::*;

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so both stages sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= COLS_NONE;
            sync_q <= COLS_NONE;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row rotation, per-key debounce, one-cycle key events.
// The row stays frozen from first detection until the debounced release.
module keypad_scanner #(
    parameter int ROW_DWELL = 4,
    parameter int DEBOUNCE  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    import keypad_scanner_pkg::*;

    localparam int CNT_W   = $clog2(DEBOUNCE + 1);
    localparam int DWELL_W = $clog2(ROW_DWELL);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(ROW_DWELL - 1);
    localparam logic [CNT_W-1:0]   CNT_DONE   = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    logic [3:0] cs;

    state_e             state_q,     state_d;
    logic [1:0]         row_idx_q,   row_idx_d;
    logic [3:0]         rows_q,      rows_d;
    logic [DWELL_W-1:0] dwell_q,     dwell_d;
    logic [CNT_W-1:0]   count_q,     count_d;
    logic [1:0]         cand_col_q,  cand_col_d;
    logic [3:0]         key_code_q,  key_code_d;
    logic               key_valid_q, key_valid_d;
    logic               key_held_q,  key_held_d;

    logic [CNT_W-1:0]   count_inc;
    col_hit_t           hit;

    key_sync u_key_sync (
        .clk (clk),
        .rst (rst),
        .d   (cols),
        .q   (cs)
    );

    assign count_inc = (count_q == CNT_DONE) ? count_q : count_q + CNT_ONE;

    always_comb begin
        // NOTE: every variable gets a default here so no path leaves one unassigned (no latches).
        hit         = find_col(cs);
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        dwell_d     = dwell_q;
        count_d     = count_q;
        cand_col_d  = cand_col_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (hit.found) begin
                        cand_col_d = hit.col;
                        count_d    = CNT_ONE;
                        state_d    = DEB_PRESS;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            DEB_PRESS: begin
                if (hit.found && hit.col == cand_col_q) begin
                    count_d = count_inc;
                    if (count_inc == CNT_DONE) begin
                        key_code_d  = {row_idx_q, cand_col_q};
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                        count_d     = '0;
                        state_d     = HELD;
                    end
                end else begin
                    // Abandoned candidate: resume scanning at the following row.
                    row_idx_d = row_idx_q + 2'd1;
                    dwell_d   = '0;
                    count_d   = '0;
                    state_d   = SCAN;
                end
            end
            HELD: begin
                if (cs[cand_col_q]) begin
                    count_d = CNT_ONE;
                    state_d = DEB_RELEASE;
                end
            end
            DEB_RELEASE: begin
                if (cs == COLS_NONE) begin
                    count_d = count_inc;
                    if (count_inc == CNT_DONE) begin
                        key_held_d = 1'b0;
                        row_idx_d  = 2'd0;
                        dwell_d    = '0;
                        count_d    = '0;
                        state_d    = SCAN;
                    end
                end else begin
                    count_d = '0;
                    state_d = HELD;
                end
            end
            default: state_d = SCAN;
        endcase

        rows_d = row_drive(row_idx_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCAN;
            row_idx_q   <= 2'd0;
            rows_q      <= ROWS_IDLE;
            dwell_q     <= '0;
            count_q     <= '0;
            cand_col_q  <= 2'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            rows_q      <= rows_d;
            dwell_q     <= dwell_d;
            count_q     <= count_d;
            cand_col_q  <= cand_col_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign rows      = rows_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed = 16'd0;

    int errors = 0;
    int checks = 0;

    int         pulse_cnt    = 0;
    logic [3:0] last_code    = 4'd0;
    logic       prev_valid   = 1'b0;
    logic       back_to_back = 1'b0;

    keypad_scanner #(.ROW_DWELL(4), .DEBOUNCE(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .cols      (cols),
        .rows      (rows),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Key (r,c) pulls column c low while row r is driven low.
    always_comb begin
        cols = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!rows[r] && pressed[r*4+c]) cols[c] = 1'b0;
    end

    always @(posedge clk) begin
        #1;
        if (key_valid) begin
            pulse_cnt++;
            last_code = key_code;
            if (prev_valid) back_to_back = 1'b1;
        end
        prev_valid = key_valid;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulse(input int max_cycles, output int at);
        at = -1;
        for (int i = 1; i <= max_cycles; i++) begin
            step(1);
            if (key_valid) begin
                at = i;
                break;
            end
        end
    endtask

    task automatic wait_held_low(input int max_cycles, output int at);
        at = -1;
        for (int i = 1; i <= max_cycles; i++) begin
            step(1);
            if (!key_held) begin
                at = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [3:0] exp_rows;
        rst = 1'b1;
        pressed = 16'd0;
        step(3);
        checks++; if (rows !== 4'b1110) begin errors++; $display("FAIL reset_rows: got %b expected 1110", rows); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", key_code); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b expected 0", key_held); end
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            exp_rows = 4'b1111;
            exp_rows[(k / 4) % 4] = 1'b0;
            checks++;
            if (rows !== exp_rows) begin
                errors++;
                $display("FAIL idle_rows[%0d]: got %b expected %b", k, rows, exp_rows);
            end
            step(1);
        end
        checks++; if (pulse_cnt !== 0) begin errors++; $display("FAIL idle_no_pulse: got %0d expected 0", pulse_cnt); end
    endtask

    task automatic test_single_key;
        int p0, at, at2;
        p0 = pulse_cnt;
        pressed[9] = 1'b1;
        wait_pulse(45, at);
        checks++; if (at < 1 || at > 38) begin errors++; $display("FAIL single_latency: got %0d expected 1..38", at); end
        checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL single_code: got %0d expected 9", key_code); end
        step(20);
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL single_held: got %b expected 1", key_held); end
        pressed = 16'd0;
        wait_held_low(40, at2);
        checks++; if (at2 !== 22) begin errors++; $display("FAIL single_release_time: got %0d expected 22", at2); end
        checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL single_pulse_count: got %0d expected 1", pulse_cnt - p0); end
        checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL single_code_hold: got %0d expected 9", key_code); end
        step(5);
    endtask

    task automatic test_bounce;
        int p0, at;
        p0 = pulse_cnt;
        pressed[4] = 1'b1;
        step(5);
        pressed[4] = 1'b0;
        step(3);
        pressed[4] = 1'b1;
        wait_pulse(40, at);
        checks++; if (at < 22 || at > 38) begin errors++; $display("FAIL bounce_latency: got %0d expected 22..38", at); end
        step(10);
        pressed = 16'd0;
        step(30);
        checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL bounce_pulse_count: got %0d expected 1", pulse_cnt - p0); end
        checks++; if (last_code !== 4'd4) begin errors++; $display("FAIL bounce_code: got %0d expected 4", last_code); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_released: got %b expected 0", key_held); end
    endtask

    task automatic test_two_keys;
        int p0, at, at2;
        p0 = pulse_cnt;
        pressed[12] = 1'b1;
        pressed[14] = 1'b1;
        wait_pulse(45, at);
        checks++; if (at < 0) begin errors++; $display("FAIL two_keys_pulse: got %0d expected a pulse", at); end
        checks++; if (key_code !== 4'd12) begin errors++; $display("FAIL two_keys_code: got %0d expected 12", key_code); end
        step(5);
        pressed[12] = 1'b0;
        step(40);
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL two_keys_held: got %b expected 1", key_held); end
        checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL two_keys_no_rollover: got %0d expected 1", pulse_cnt - p0); end
        pressed = 16'd0;
        wait_held_low(40, at2);
        checks++; if (at2 < 21 || at2 > 22) begin errors++; $display("FAIL two_keys_release_time: got %0d expected 21..22", at2); end
        step(5);
    endtask

    task automatic test_reset_mid_press;
        int p0, at;
        rst = 1'b1;
        step(2);
        p0 = pulse_cnt;
        rst = 1'b0;
        pressed[8] = 1'b1;
        step(21);
        checks++; if (rows !== 4'b1011) begin errors++; $display("FAIL midrst_frozen_row: got %b expected 1011", rows); end
        rst = 1'b1;
        step(1);
        checks++; if (rows !== 4'b1110) begin errors++; $display("FAIL midrst_rows: got %b expected 1110", rows); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL midrst_held: got %b expected 0", key_held); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL midrst_code: got %0d expected 0", key_code); end
        step(2);
        checks++; if (pulse_cnt - p0 !== 0) begin errors++; $display("FAIL midrst_no_pulse: got %0d expected 0", pulse_cnt - p0); end
        rst = 1'b0;
        wait_pulse(45, at);
        checks++; if (at < 22 || at > 38) begin errors++; $display("FAIL midrst_after_latency: got %0d expected 22..38", at); end
        checks++; if (key_code !== 4'd8) begin errors++; $display("FAIL midrst_after_code: got %0d expected 8", key_code); end
        pressed = 16'd0;
        step(30);
    endtask

    task automatic test_release_glitch;
        int p0, at, at2;
        p0 = pulse_cnt;
        pressed[6] = 1'b1;
        wait_pulse(45, at);
        checks++; if (key_code !== 4'd6) begin errors++; $display("FAIL glitch_code: got %0d expected 6", key_code); end
        step(5);
        pressed[6] = 1'b0;
        step(15);
        pressed[6] = 1'b1;
        step(1);
        pressed[6] = 1'b0;
        step(14);
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL glitch_held: got %b expected 1", key_held); end
        wait_held_low(20, at2);
        checks++; if (at2 !== 8) begin errors++; $display("FAIL glitch_release_time: got %0d expected 8", at2); end
        checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL glitch_pulse_count: got %0d expected 1", pulse_cnt - p0); end
        step(5);
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_bounce();
        test_two_keys();
        test_reset_mid_press();
        test_release_glitch();
        checks++; if (back_to_back !== 1'b0) begin errors++; $display("FAIL valid_back_to_back: got %b expected 0", back_to_back); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
